divmod_result_fifo: RTL and testbench
=====================================

Name: divmod_result_fifo

Overview:
- Buffers quotient/remainder results from the divider stage and presents them to a downstream consumer over a ready/valid interface.
- Needed because the divider pulses its valid for exactly one cycle and takes no backpressure.
- Tags each entry with a divide-by-zero flag.
- Reports fill level and a sticky overflow flag, so the issuing logic can stop sending operands when the buffer is full.

Parameters:
- DEPTH, 4, number of result entries; must be a power of two, at least 2.
- WIDTH, 32, width of each payload field (quotient and remainder).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_valid  input  1  one-cycle result strobe from the divider.
- i_payload_1  input  WIDTH  quotient.
- i_payload_2  input  WIDTH  remainder.
- i_ready  output  1  buffer can accept a result this cycle (not full, or full with a pop this cycle); the issuer gates new operands on it.
- o_valid  output  1  head entry valid.
- o_ready  input  1  consumer accepts the head entry.
- o_payload_1  output  WIDTH  head quotient.
- o_payload_2  output  WIDTH  head remainder.
- o_div_by_zero  output  1  head entry is a divide-by-zero result.
- o_level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- o_overflow  output  1  sticky: a result arrived while the buffer could not accept it.
- i_clear_overflow  input  1  synchronous clear of o_overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - read pointer, write pointer and count go to 0.
  - o_valid=0, o_level=0, o_overflow=0, i_ready=1.
  - o_payload_1, o_payload_2 and o_div_by_zero read 0. Storage array is not reset, so the payload outputs are masked to 0 while empty.
  - Reset mid-operation discards all entries immediately. No output glitches back to valid until a new push.
- Organisation: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0, plus a separate count register. Full is count==DEPTH; empty is count==0.
- Push occurs when i_valid=1 and (count<DEPTH or pop this cycle). It stores {div_by_zero, payload_1, payload_2} at the write pointer, then advances the write pointer.
- Divide-by-zero tag: set exactly when i_payload_1 and i_payload_2 are both all-ones. A legitimate result cannot produce this pattern, because remainder < divisor ≤ 2^WIDTH-1.
- Pop occurs when o_valid=1 and o_ready=1, and advances the read pointer.
- Output is first-word-fall-through:
  - o_valid = (count!=0).
  - Head fields are read from the read-pointer entry.
- Latency: a push into an empty buffer is visible at the outputs on the next cycle. There is no combinational path from i_valid or i_payload to any output.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Simultaneous push and pop:
  - when full: both happen and the level stays at DEPTH.
  - when empty: only the push happens, since o_valid=0.
- o_level equals count, registered.
- Overflow (i_valid=1, buffer full, no pop):
  - the result is dropped and the contents are unchanged.
  - o_overflow is set the next cycle and held until i_clear_overflow=1 or reset.
  - if a new overflow coincides with i_clear_overflow, the set wins.
- i_ready = (count<DEPTH) || (o_valid && o_ready). This is combinational from o_ready only.
- o_ready held at 0 stalls the head indefinitely; o_payload_1, o_payload_2 and o_div_by_zero stay stable while o_valid=1 and o_ready=0.

Optional Feature:
- Macro: DIVMOD_RESULT_STATS_EN
- When defined, two extra output ports are added; both reset to 0 and neither wraps:
  - o_result_count, output, 32 bits: accepted pushes, saturating at 32'hFFFFFFFF.
  - o_dz_count, output, 16 bits: accepted pushes tagged divide-by-zero, saturating at 16'hFFFF.
- Dropped (overflow) results are not counted.
- When undefined, these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset, then push (17→q=3, r=2) with o_ready=1. Expect o_valid=1 one cycle later with o_payload_1=3, o_payload_2=2, o_div_by_zero=0, o_level=1; the entry pops and o_level returns to 0.
2. With o_ready=0 and DEPTH=4, push results q=0..4 (r=q). Expect:
   - o_level=4 and i_ready=0 after the fourth push.
   - the fifth push is dropped and o_overflow=1.
   - raising o_ready drains q=0,1,2,3 in order, then o_valid=0.
3. Push q=r=32'hFFFFFFFF, then q=32'hFFFFFFFF with r=0. Expect:
   - first entry: o_div_by_zero=1.
   - second entry: o_div_by_zero=0 (dividend 32'hFFFFFFFF, divisor 1).
4. Buffer full, o_ready=1 and i_valid=1 in the same cycle (q=9). Expect:
   - i_ready=1 that cycle.
   - the head pops, q=9 is stored, o_level stays 4 and o_overflow stays 0.
   - running more than DEPTH such cycles exercises pointer wrap with data order preserved.
5. Three entries queued, then reset pulled low for one cycle mid-stream. Expect:
   - o_valid=0, o_level=0 and o_payload outputs at 0 immediately, without waiting for a clock edge.
   - a subsequent push (q=5, r=1) is output correctly.
6. With DIVMOD_RESULT_STATS_EN defined: 3 normal pushes, 2 divide-by-zero pushes, and 1 overflow drop. Expect o_result_count=5 and o_dz_count=2.

Source files
------------

// File: rtl/divmod_result_fifo.sv
// divmod_result_fifo: first-word-fall-through result buffer behind the divider.
// The divider strobes a result for one cycle and cannot be stalled, so every
// result is captured here, tagged with a divide-by-zero flag, and handed to
// the consumer over ready/valid. The fill level and a sticky overflow flag let
// the issuer stop sending operands while the buffer is full.
// Optional: define DIVMOD_RESULT_STATS_EN to add saturating counters of
// accepted results and accepted divide-by-zero results.
module divmod_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_payload_1,
    input  logic [WIDTH-1:0]         i_payload_2,
    output logic                     i_ready,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [WIDTH-1:0]         o_payload_1,
    output logic [WIDTH-1:0]         o_payload_2,
    output logic                     o_div_by_zero,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clear_overflow
`ifdef DIVMOD_RESULT_STATS_EN
    ,
    output logic [31:0]              o_result_count,
    output logic [15:0]              o_dz_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    typedef struct packed {
        logic             dz;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_dz;
    entry_t          w_head;

    assign w_full  = (r_count == LP_DEPTH);
    assign o_valid = (r_count != '0);
    assign w_pop   = o_valid & o_ready;
    // A full buffer still accepts a result when the head leaves in the same cycle.
    assign w_push  = i_valid & (~w_full | w_pop);
    assign w_drop  = i_valid & w_full & ~w_pop;
    assign i_ready = ~w_full | w_pop;

    // Remainder is always below the divisor, so q=r=all-ones only comes from /0.
    assign w_dz = (&i_payload_1) & (&i_payload_2);

    // Head fields masked while empty because the storage itself is never reset.
    assign w_head        = r_mem[r_rd_ptr];
    assign o_payload_1   = o_valid ? w_head.q  : '0;
    assign o_payload_2   = o_valid ? w_head.r  : '0;
    assign o_div_by_zero = o_valid ? w_head.dz : 1'b0;
    assign o_level       = r_count;
    assign o_overflow    = r_overflow;

    // Storage write; no reset so it maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{dz: w_dz, q: i_payload_1, r: i_payload_2};
        end
    end

    // Pointers and count; power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DIVMOD_RESULT_STATS_EN
    logic [31:0] r_result_count;
    logic [15:0] r_dz_count;

    // Saturating counters of accepted results; dropped results are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result_count <= '0;
            r_dz_count     <= '0;
        end else if (w_push) begin
            if (r_result_count != 32'hFFFF_FFFF) r_result_count <= r_result_count + 32'd1;
            if (w_dz && (r_dz_count != 16'hFFFF)) r_dz_count <= r_dz_count + 16'd1;
        end
    end

    assign o_result_count = r_result_count;
    assign o_dz_count     = r_dz_count;
`endif

endmodule

// File: tb/tb_divmod_result_fifo.sv
// Bench for divmod_result_fifo: per-cycle vector table for the main flows
// plus hand-written sequences for asynchronous reset and the stats counters.
module tb_divmod_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic [WIDTH-1:0] i_payload_1;
    logic [WIDTH-1:0] i_payload_2;
    logic             i_ready;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_payload_1;
    logic [WIDTH-1:0] o_payload_2;
    logic             o_div_by_zero;
    logic [2:0]       o_level;
    logic             o_overflow;
    logic             i_clear_overflow;
`ifdef DIVMOD_RESULT_STATS_EN
    logic [31:0]      o_result_count;
    logic [15:0]      o_dz_count;
`endif

    divmod_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .i_valid          (i_valid),
        .i_payload_1      (i_payload_1),
        .i_payload_2      (i_payload_2),
        .i_ready          (i_ready),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_payload_1      (o_payload_1),
        .o_payload_2      (o_payload_2),
        .o_div_by_zero    (o_div_by_zero),
        .o_level          (o_level),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow)
`ifdef DIVMOD_RESULT_STATS_EN
        ,
        .o_result_count   (o_result_count),
        .o_dz_count       (o_dz_count)
`endif
    );

    always #5 clk = ~clk;

    // One record per cycle: inputs driven that cycle and outputs expected
    // before the next rising edge.
    typedef struct {
        logic        push;
        logic [31:0] q;
        logic [31:0] r;
        logic        ordy;
        logic        clr;
        logic        ev;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic [2:0]  elvl;
        logic        erdy;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic push, input logic [31:0] q, input logic [31:0] r,
                       input logic ordy, input logic clr, input logic ev,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input logic [2:0] elvl, input logic erdy, input logic eovf);
        vec_t v;
        v = '{push, q, r, ordy, clr, ev, eq, er, edz, elvl, erdy, eovf};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic push, input logic [31:0] q, input logic [31:0] r,
                       input logic ordy, input logic clr);
        @(negedge clk);
        i_valid = push; i_payload_1 = q; i_payload_2 = r;
        o_ready = ordy; i_clear_overflow = clr;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] eq,
                           input logic [31:0] er, input logic edz, input logic [2:0] elvl,
                           input logic erdy, input logic eovf);
        chk({tag, " o_valid"},       32'(o_valid),       32'(ev));
        chk({tag, " o_payload_1"},   o_payload_1,        eq);
        chk({tag, " o_payload_2"},   o_payload_2,        er);
        chk({tag, " o_div_by_zero"}, 32'(o_div_by_zero), 32'(edz));
        chk({tag, " o_level"},       32'(o_level),       32'(elvl));
        chk({tag, " i_ready"},       32'(i_ready),       32'(erdy));
        chk({tag, " o_overflow"},    32'(o_overflow),    32'(eovf));
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_payload_1 = '0; i_payload_2 = '0;
        o_ready = 1'b0; i_clear_overflow = 1'b0;

        //   push q      r      ordy clr | v  q      r      dz lvl rdy ovf
        // basic push then pop
        add(1, 17'd0+3, 2,    1, 0,   0, 0,    0,    0, 0, 1, 0);
        add(0, 0,      0,     1, 0,   1, 3,    2,    0, 1, 1, 0);
        add(0, 0,      0,     0, 0,   0, 0,    0,    0, 0, 1, 0);
        // fill with o_ready=0, fifth push dropped, drain in order, clear overflow
        add(1, 0,      0,     0, 0,   0, 0,    0,    0, 0, 1, 0);
        add(1, 1,      1,     0, 0,   1, 0,    0,    0, 1, 1, 0);
        add(1, 2,      2,     0, 0,   1, 0,    0,    0, 2, 1, 0);
        add(1, 3,      3,     0, 0,   1, 0,    0,    0, 3, 1, 0);
        add(1, 4,      4,     0, 0,   1, 0,    0,    0, 4, 0, 0);
        add(0, 0,      0,     0, 0,   1, 0,    0,    0, 4, 0, 1);
        add(0, 0,      0,     1, 0,   1, 0,    0,    0, 4, 1, 1);
        add(0, 0,      0,     1, 0,   1, 1,    1,    0, 3, 1, 1);
        add(0, 0,      0,     1, 0,   1, 2,    2,    0, 2, 1, 1);
        add(0, 0,      0,     1, 0,   1, 3,    3,    0, 1, 1, 1);
        add(0, 0,      0,     0, 1,   0, 0,    0,    0, 0, 1, 1);
        add(0, 0,      0,     0, 0,   0, 0,    0,    0, 0, 1, 0);
        // divide-by-zero tagging
        add(1, ONES,   ONES,  0, 0,   0, 0,    0,    0, 0, 1, 0);
        add(1, ONES,   0,     0, 0,   1, ONES, ONES, 1, 1, 1, 0);
        add(0, 0,      0,     1, 0,   1, ONES, ONES, 1, 2, 1, 0);
        add(0, 0,      0,     1, 0,   1, ONES, 0,    0, 1, 1, 0);
        add(0, 0,      0,     0, 0,   0, 0,    0,    0, 0, 1, 0);
        // full with simultaneous push/pop, pointers wrap
        add(1, 10,     10,    0, 0,   0, 0,    0,    0, 0, 1, 0);
        add(1, 11,     11,    0, 0,   1, 10,   10,   0, 1, 1, 0);
        add(1, 12,     12,    0, 0,   1, 10,   10,   0, 2, 1, 0);
        add(1, 13,     13,    0, 0,   1, 10,   10,   0, 3, 1, 0);
        add(1, 9,      9,     1, 0,   1, 10,   10,   0, 4, 1, 0);
        add(1, 20,     20,    1, 0,   1, 11,   11,   0, 4, 1, 0);
        add(1, 21,     21,    1, 0,   1, 12,   12,   0, 4, 1, 0);
        add(1, 22,     22,    1, 0,   1, 13,   13,   0, 4, 1, 0);
        add(1, 23,     23,    1, 0,   1, 9,    9,    0, 4, 1, 0);
        add(0, 0,      0,     1, 0,   1, 20,   20,   0, 4, 1, 0);
        add(0, 0,      0,     1, 0,   1, 21,   21,   0, 3, 1, 0);
        add(0, 0,      0,     1, 0,   1, 22,   22,   0, 2, 1, 0);
        add(0, 0,      0,     1, 0,   1, 23,   23,   0, 1, 1, 0);
        add(0, 0,      0,     0, 0,   0, 0,    0,    0, 0, 1, 0);

        // reset state
        #12;
        chk_out("reset", 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drv(vecs[i].push, vecs[i].q, vecs[i].r, vecs[i].ordy, vecs[i].clr);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eq, vecs[i].er,
                    vecs[i].edz, vecs[i].elvl, vecs[i].erdy, vecs[i].eovf);
        end

        // asynchronous reset mid-stream discards queued entries at once
        drv(1, 1, 1, 0, 0);
        drv(1, 2, 2, 0, 0);
        drv(1, 3, 3, 0, 0);
        drv(0, 0, 0, 0, 0);
        #1;
        chk_out("prereset", 1, 1, 1, 0, 3, 1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk_out("rst_held", 0, 0, 0, 0, 0, 1, 0);
        drv(1, 5, 1, 0, 0);
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0);
        #1;
        chk_out("post_rst", 1, 5, 1, 0, 1, 1, 0);

`ifdef DIVMOD_RESULT_STATS_EN
        // stats: 3 normal + 2 divide-by-zero accepted, 1 dropped
        #1;
        rst_n = 1'b0;
        #1;
        chk("stats_rst result_count", o_result_count, 0);
        chk("stats_rst dz_count", 32'(o_dz_count), 0);
        rst_n = 1'b1;
        drv(1, 1, 0, 0, 0);
        drv(1, 2, 0, 0, 0);
        drv(1, 3, 0, 0, 0);
        drv(1, ONES, ONES, 0, 0);
        drv(1, ONES, ONES, 1, 0);
        drv(1, 7, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        #1;
        chk("stats result_count", o_result_count, 5);
        chk("stats dz_count", 32'(o_dz_count), 2);
        chk("stats o_overflow", 32'(o_overflow), 1);
        chk("stats o_level", 32'(o_level), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
